// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pc_sequencer
// Next-PC selection for program_counter: fetch FSM, branch-target LUT and
// return-address stack.
// Rev    : 1.0
// ============================================================================
module pc_sequencer #(
    parameter int D = 12,
    parameter int L = 4,
    parameter int S = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [D-1:0] pc_out,
    input  logic [D-1:0] pc_added,
    input  logic         stall,
    input  logic         branch,
    input  logic         cond,
    input  logic         call,
    input  logic         ret,
    input  logic         halt,
    input  logic [L-1:0] tgt_idx,
    input  logic         cfg_we,
    input  logic [L-1:0] cfg_idx,
    input  logic [D-1:0] cfg_data,
    output logic [D-1:0] pc_in,
    output logic [1:0]   state,
    output logic         done,
    output logic         stack_err
);
    localparam int             SPW     = $clog2(S + 1);
    localparam int             IW      = (S > 1) ? $clog2(S) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(S);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t         cur_state;
    state_t         nxt_state;
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_m1;
    logic [D-1:0]   lut   [2**L];
    logic [D-1:0]   stack [S];
    logic [D-1:0]   pc_sel;
    logic           push;
    logic           pop;
    logic           err_set;
    logic           sp_clr;
    logic           done_q;
    logic           err_q;

    assign sp_m1 = sp - SPW'(1);

    // Next-PC and control decisions; priority order matches the RUN decode.
    always_comb begin
        pc_sel    = pc_out;
        nxt_state = cur_state;
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;
        sp_clr    = 1'b0;
        case (cur_state)
            IDLE: begin
                if (start) begin
                    pc_sel    = '0;
                    nxt_state = RUN;
                end
            end
            RUN: begin
                if (stall) begin
                    pc_sel = pc_out;
                end else if (halt) begin
                    nxt_state = HALTED;
                end else if (ret) begin
                    if (sp != '0) begin
                        pc_sel = stack[sp_m1[IW-1:0]];
                        pop    = 1'b1;
                    end else begin
                        err_set   = 1'b1;
                        nxt_state = HALTED;
                    end
                end else if (call) begin
                    if (sp < SP_FULL) begin
                        pc_sel = lut[tgt_idx];
                        push   = 1'b1;
                    end else begin
                        err_set   = 1'b1;
                        nxt_state = HALTED;
                    end
                end else if (branch && cond) begin
                    pc_sel = lut[tgt_idx];
                end else begin
                    pc_sel = pc_added;
                end
            end
            HALTED: begin
                if (start) begin
                    pc_sel    = '0;
                    nxt_state = RUN;
                    sp_clr    = 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
            sp        <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < 2**L; i++) begin
                lut[i] <= '0;
            end
            for (int i = 0; i < S; i++) begin
                stack[i] <= '0;
            end
        end else begin
            cur_state <= nxt_state;
            done_q    <= (nxt_state == HALTED);
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (sp_clr) begin
                sp <= '0;
            end else if (pop) begin
                sp <= sp_m1;
            end else if (push) begin
                stack[sp[IW-1:0]] <= pc_added;
                sp                <= sp + SPW'(1);
            end
            // Reads above see the pre-edge LUT contents, so a same-index write is not forwarded.
            if (cfg_we) begin
                lut[cfg_idx] <= cfg_data;
            end
        end
    end

    assign pc_in     = reset ? '0 : pc_sel;
    assign state     = cur_state;
    assign done      = done_q;
    assign stack_err = err_q;

endmodule
`default_nettype wire
